// File: rtl/sram_rw_arbiter_if.sv
// Requester-side bundle for one port of the SRAM RW arbiter: request handshake plus response.
// Latency: none (wiring only).
// Backpressure: req_ready gates acceptance; responses cannot be stalled.
// Ports: req_valid/req_ready handshake, req_we/req_wmask/req_addr/req_wdata request fields,
//        rsp_valid pulse with rsp_rdata.
// The master modport is the requester; the slave modport is the arbiter.
interface sram_rw_arbiter_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter sharing port 0 (RW) of a 32x512 OpenRAM macro between requesters a and b.
// Latency: response (read data or write ack) exactly 2 cycles after acceptance.
// Backpressure: ready goes only to the granted requester; responses cannot be stalled.
// Ports: clk, rst (synchronous, active-high); a, b (sram_rw_arbiter_if.slave);
//        sram_csb0/web0/wmask0/addr0/din0 drive the macro, sram_dout0 is its read data;
//        init_done is high while the arbiter accepts requests.
// Optional feature: define SRAM_ARB_ZERO_INIT_EN to zero the whole macro after every reset
// (512 write cycles) before any request is accepted.
module sram_rw_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_rw_arbiter_if.slave      a,
    sram_rw_arbiter_if.slave      b,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic run;
    logic grant_a;
    logic grant_b;
    logic acc_a;
    logic acc_b;
    logic last_b;     // 1 when b owns the most recent accepted request

    // Response pipeline stage 1: request committed to the macro last cycle.
    logic s1_vld;
    logic s1_own_b;
    logic s1_rd;

`ifdef SRAM_ARB_ZERO_INIT_EN
    // One extra bit so the counter can reach the word count and flag completion.
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
    localparam logic [ADDR_WIDTH:0] CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] init_cnt;
    logic [ADDR_WIDTH:0] init_cnt_nxt;

    assign init_cnt_nxt = init_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SRAM_ARB_ZERO_INIT_EN
            state <= ST_INIT;
`else
            state <= ST_RUN;
`endif
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef SRAM_ARB_ZERO_INIT_EN
        // Leave INIT once the write to the last word has been driven.
        if ((state == ST_INIT) && (init_cnt_nxt == CNT_END)) begin
            state_nxt = ST_RUN;
        end
`else
        state_nxt = ST_RUN;
`endif
    end

    // Rst gates everything combinationally so the pins and ready are quiet during
    // the reset cycle itself, before the synchronous reset has taken effect.
    assign run       = (state == ST_RUN) & ~rst;
    assign init_done = run;

    // A wins when alone, or on a tie when b was served last.
    assign grant_a = a.req_valid & (~b.req_valid | last_b);
    assign grant_b = b.req_valid & ~grant_a;

    assign a.req_ready = grant_a & run;
    assign b.req_ready = grant_b & run;
    assign acc_a       = a.req_valid & a.req_ready;
    assign acc_b       = b.req_valid & b.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (acc_a) begin
            last_b <= 1'b0;
        end else if (acc_b) begin
            last_b <= 1'b1;
        end
    end

    // Macro port-0 pins are driven in the accept cycle; the macro registers them
    // at the closing posedge.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (acc_a) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~a.req_we;
            sram_wmask0 = a.req_wmask;
            sram_addr0  = a.req_addr;
            sram_din0   = a.req_wdata;
        end else if (acc_b) begin
            sram_csb0   = 1'b0;
            sram_web0   = ~b.req_we;
            sram_wmask0 = b.req_wmask;
            sram_addr0  = b.req_addr;
            sram_din0   = b.req_wdata;
        end
`ifdef SRAM_ARB_ZERO_INIT_EN
        else if ((state == ST_INIT) && !rst) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = init_cnt[ADDR_WIDTH-1:0];
            sram_din0   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_own_b <= 1'b0;
            s1_rd    <= 1'b0;
        end else begin
            s1_vld   <= acc_a | acc_b;
            s1_own_b <= acc_b;
            s1_rd    <= acc_a ? ~a.req_we : ~b.req_we;
        end
    end

    // Stage 2: the macro read at the mid-cycle negedge, so dout0 is stable here.
    // rdata registers only load on their own response and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            a.rsp_valid <= 1'b0;
            b.rsp_valid <= 1'b0;
            a.rsp_rdata <= '0;
            b.rsp_rdata <= '0;
        end else begin
            a.rsp_valid <= s1_vld & ~s1_own_b;
            b.rsp_valid <= s1_vld & s1_own_b;
            if (s1_vld && !s1_own_b) begin
                a.rsp_rdata <= s1_rd ? sram_dout0 : '0;
            end
            if (s1_vld && s1_own_b) begin
                b.rsp_rdata <= s1_rd ? sram_dout0 : '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter with a behavioural OpenRAM-style macro on port 0.
// Directed requests push expected responses (data and due cycle) into per-requester
// queues; a negedge monitor pops and compares whenever rsp_valid is seen.
`timescale 1ns/1ps
module tb_sram_rw_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_rw_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) a_if ();
    sram_rw_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) b_if ();

    logic          sram_csb0;
    logic          sram_web0;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;
    logic          init_done;

    sram_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a_if.slave),
        .b           (b_if.slave),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .init_done   (init_done)
    );

    // ---------------- macro model: inputs at posedge, access at negedge ----------------
    logic [DW-1:0] mem [0:511];
    logic          mem_loaded = 1'b0;
    logic          m_csb = 1'b1;
    logic          m_web = 1'b1;
    logic [MW-1:0] m_wmask = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0;

    always @(posedge clk) begin
        m_csb   <= sram_csb0;
        m_web   <= sram_web0;
        m_wmask <= sram_wmask0;
        m_addr  <= sram_addr0;
        m_din   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!mem_loaded) begin
            // Non-zero power-up pattern so zero-fill is observable.
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5_0000 | i;
            mem_loaded <= 1'b1;
        end else if (m_csb === 1'b0) begin
            if (m_web) begin
                sram_dout0 <= mem[m_addr];
            end else begin
                for (int i = 0; i < MW; i++)
                    if (m_wmask[i]) mem[m_addr][8*i +: 8] <= m_din[8*i +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    typedef struct packed {
        logic        vld;
        logic        we;
        logic [3:0]  wm;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } req_t;

    localparam req_t NOREQ = '0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int n_checks = 0;
    int n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a_if.rsp_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_rsp: got rsp_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                ea = qa.pop_front();
                chk("a_rsp_rdata", a_if.rsp_rdata, ea.data);
                chk("a_rsp_cycle", cyc, ea.due);
            end
        end
        if (b_if.rsp_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_rsp: got rsp_valid=1, expected none (cycle %0d)", cyc);
            end else begin
                eb = qb.pop_front();
                chk("b_rsp_rdata", b_if.rsp_rdata, eb.data);
                chk("b_rsp_cycle", cyc, eb.due);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic req_t rd(input logic [8:0] ad, input logic [31:0] ex);
        req_t r;
        r = '0;
        r.vld = 1'b1;
        r.addr = ad;
        r.exp = ex;
        return r;
    endfunction

    function automatic req_t wr(input logic [8:0] ad, input logic [3:0] m, input logic [31:0] d);
        req_t r;
        r = '0;
        r.vld = 1'b1;
        r.we = 1'b1;
        r.wm = m;
        r.addr = ad;
        r.wd = d;
        r.exp = 32'h0;
        return r;
    endfunction

    task automatic drive(input req_t ra, input req_t rb);
        a_if.req_valid = ra.vld;
        a_if.req_we    = ra.we;
        a_if.req_wmask = ra.wm;
        a_if.req_addr  = ra.addr;
        a_if.req_wdata = ra.wd;
        b_if.req_valid = rb.vld;
        b_if.req_we    = rb.we;
        b_if.req_wmask = rb.wm;
        b_if.req_addr  = rb.addr;
        b_if.req_wdata = rb.wd;
    endtask

    task automatic push_acc(input req_t ra, input req_t rb);
        exp_t e;
        if (a_if.req_valid && a_if.req_ready) begin
            e.data = ra.exp;
            e.due  = cyc + 2;
            qa.push_back(e);
        end
        if (b_if.req_valid && b_if.req_ready) begin
            e.data = rb.exp;
            e.due  = cyc + 2;
            qb.push_back(e);
        end
    endtask

    // One cycle: drive, check grant/ready and chip select at negedge, record acceptances.
    task automatic step(input string tag, input req_t ra, input req_t rb,
                        input logic er_a, input logic er_b);
        logic exp_csb;
        exp_csb = !(er_a || er_b);
        drive(ra, rb);
        @(negedge clk);
        chk({tag, "_a_ready"}, a_if.req_ready, er_a);
        chk({tag, "_b_ready"}, b_if.req_ready, er_b);
        chk({tag, "_csb0"}, sram_csb0, exp_csb);
        chk({tag, "_init_done"}, init_done, 1'b1);
        push_acc(ra, rb);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_ready"}, a_if.req_ready, 1'b0);
        chk({tag, "_b_ready"}, b_if.req_ready, 1'b0);
        chk({tag, "_a_rsp_valid"}, a_if.rsp_valid, 1'b0);
        chk({tag, "_b_rsp_valid"}, b_if.rsp_valid, 1'b0);
        chk({tag, "_a_rsp_rdata"}, a_if.rsp_rdata, 32'h0);
        chk({tag, "_b_rsp_rdata"}, b_if.rsp_rdata, 32'h0);
        chk({tag, "_csb0"}, sram_csb0, 1'b1);
        chk({tag, "_web0"}, sram_web0, 1'b1);
        chk({tag, "_wmask0"}, sram_wmask0, 4'h0);
        chk({tag, "_addr0"}, sram_addr0, 9'h0);
        chk({tag, "_din0"}, sram_din0, 32'h0);
        chk({tag, "_init_done"}, init_done, 1'b0);
    endtask

    // After reset with zero-fill: both requesters wait; A must win the first tie once
    // 512 fill cycles have passed, and the fill must have cleared words 510/511.
    task automatic wait_init();
`ifdef SRAM_ARB_ZERO_INIT_EN
        int   n_wait;
        int   n_early;
        bit   got;
        req_t ra;
        req_t rb;
        n_wait  = 0;
        n_early = 0;
        got     = 1'b0;
        ra = rd(9'd511, 32'h0);
        rb = rd(9'd510, 32'h0);
        drive(ra, rb);
        while (!got && n_wait < 600) begin
            @(negedge clk);
            if (a_if.req_ready || b_if.req_ready) begin
                got = 1'b1;
            end else begin
                n_wait++;
                if (init_done !== 1'b0) n_early++;
                @(posedge clk);
                #1;
            end
        end
        chk("init_wait_cycles", n_wait, 512);
        chk("init_done_early", n_early, 0);
        chk("init_done_rise", init_done, 1'b1);
        chk("init_tie_a_ready", a_if.req_ready, 1'b1);
        chk("init_tie_b_ready", b_if.req_ready, 1'b0);
        push_acc(ra, rb);
        @(posedge clk);
        #1;
        step("init_rd_b", NOREQ, rb, 1'b0, 1'b1);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        drive(NOREQ, NOREQ);
        @(posedge clk);
        #1;
        // Valids during reset must not produce ready or macro activity.
        drive(rd(9'd0, 32'h0), rd(9'd0, 32'h0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(NOREQ, NOREQ);
        wait_init();

        // Write then read-after-write, same address, consecutive cycles.
        step("wr5", wr(9'd5, 4'hF, 32'hDEADBEEF), NOREQ, 1'b1, 1'b0);
        step("rd5", rd(9'd5, 32'hDEADBEEF), NOREQ, 1'b1, 1'b0);

        // Byte lanes: lanes 0 and 2 replaced.
        step("wr7a", wr(9'd7, 4'hF, 32'h11223344), NOREQ, 1'b1, 1'b0);
        step("wr7b", wr(9'd7, 4'b0101, 32'hAABBCCDD), NOREQ, 1'b1, 1'b0);
        step("rd7", rd(9'd7, 32'h11BB33DD), NOREQ, 1'b1, 1'b0);
        // Zero mask write is acked but leaves memory unchanged.
        step("wr7z", wr(9'd7, 4'h0, 32'hFFFFFFFF), NOREQ, 1'b1, 1'b0);
        step("rd7z", rd(9'd7, 32'h11BB33DD), NOREQ, 1'b1, 1'b0);

        // Preload for contention; lone requesters are always granted.
        step("wr1", wr(9'd1, 4'hF, 32'h11111111), NOREQ, 1'b1, 1'b0);
        step("wr2", NOREQ, wr(9'd2, 4'hF, 32'h22222222), 1'b0, 1'b1);

        // Both hold valid for 4 cycles: alternate A,B,A,B.
        step("cont0", rd(9'd1, 32'h11111111), rd(9'd2, 32'h22222222), 1'b1, 1'b0);
        step("cont1", rd(9'd1, 32'h11111111), rd(9'd2, 32'h22222222), 1'b0, 1'b1);
        step("cont2", rd(9'd1, 32'h11111111), rd(9'd2, 32'h22222222), 1'b1, 1'b0);
        step("cont3", rd(9'd1, 32'h11111111), rd(9'd2, 32'h22222222), 1'b0, 1'b1);

        // Cross-requester read-after-write.
        step("xwr3", wr(9'd3, 4'hF, 32'hCAFEF00D), NOREQ, 1'b1, 1'b0);
        step("xrd3", NOREQ, rd(9'd3, 32'hCAFEF00D), 1'b0, 1'b1);

        // Tie after B served goes to A; B then follows.
        step("tw0", wr(9'd4, 4'hF, 32'h12345678), wr(9'd6, 4'hF, 32'h87654321), 1'b1, 1'b0);
        step("tw1", NOREQ, wr(9'd6, 4'hF, 32'h87654321), 1'b0, 1'b1);
        step("tr0", rd(9'd4, 32'h12345678), rd(9'd6, 32'h87654321), 1'b1, 1'b0);
        step("tr1", NOREQ, rd(9'd6, 32'h87654321), 1'b0, 1'b1);

        // Idle: no grants, chip deselected, no spurious responses.
        for (int i = 0; i < 10; i++) step("idle", NOREQ, NOREQ, 1'b0, 1'b0);

        // Reset the cycle after an A acceptance: its response is dropped.
        step("pre_rst", rd(9'd5, 32'hDEADBEEF), NOREQ, 1'b1, 1'b0);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        drive(rd(9'd5, 32'h0), rd(9'd2, 32'h0));
        @(negedge clk);
        chk("rst_edge_a_ready", a_if.req_ready, 1'b0);
        chk("rst_edge_b_ready", b_if.req_ready, 1'b0);
        chk("rst_edge_csb0", sram_csb0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(NOREQ, NOREQ);
        wait_init();
`ifndef SRAM_ARB_ZERO_INIT_EN
        // Last accept before reset was A; reset must restore A-first tie breaking.
        step("tie_after_rst", rd(9'd5, 32'hDEADBEEF), rd(9'd2, 32'h22222222), 1'b1, 1'b0);
        step("b_after_rst", NOREQ, rd(9'd2, 32'h22222222), 1'b0, 1'b1);
`endif

        for (int i = 0; i < 4; i++) step("drain", NOREQ, NOREQ, 1'b0, 1'b0);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "timeout");
    end

endmodule
